// File: rtl/alu_md_pkg.sv
// alu_md_pkg: shared encodings for the execute-stage ALU and the iterative
// multiply/divide unit.
//   ALUOP_* : 5-bit combinational ALU opcodes (decoder ALUOp field)
//   MDOP_*  : 3-bit multiply/divide/HI-LO opcodes (decoder md_op field)
//   md_state_e : iterative unit sequencing states
package alu_md_pkg;

  localparam logic [4:0] ALUOP_ADDU = 5'd0;
  localparam logic [4:0] ALUOP_ADD  = 5'd1;
  localparam logic [4:0] ALUOP_SUBU = 5'd2;
  localparam logic [4:0] ALUOP_SUB  = 5'd3;
  localparam logic [4:0] ALUOP_AND  = 5'd4;
  localparam logic [4:0] ALUOP_OR   = 5'd5;
  localparam logic [4:0] ALUOP_NOR  = 5'd6;
  localparam logic [4:0] ALUOP_XOR  = 5'd7;
  localparam logic [4:0] ALUOP_SLT  = 5'd8;
  localparam logic [4:0] ALUOP_SLTU = 5'd9;
  localparam logic [4:0] ALUOP_SLL  = 5'd10;
  localparam logic [4:0] ALUOP_SRL  = 5'd11;
  localparam logic [4:0] ALUOP_SRA  = 5'd12;

  localparam logic [2:0] MDOP_NONE  = 3'd0;
  localparam logic [2:0] MDOP_MULT  = 3'd1;
  localparam logic [2:0] MDOP_MULTU = 3'd2;
  localparam logic [2:0] MDOP_DIV   = 3'd3;
  localparam logic [2:0] MDOP_DIVU  = 3'd4;
  localparam logic [2:0] MDOP_MTHI  = 3'd5;
  localparam logic [2:0] MDOP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  // True for the opcodes that go through the iterative datapath.
  function automatic logic is_iter_op(input logic [2:0] op);
    return (op == MDOP_MULT) || (op == MDOP_MULTU) ||
           (op == MDOP_DIV)  || (op == MDOP_DIVU);
  endfunction

endpackage

// File: rtl/alu_md_iter.sv
// md_iter: iterative multiply/divide datapath.
//   start          : accept a MULT/MULTU/DIV/DIVU with operands a/b (caller gates busy/flush)
//   flush          : abort, return to idle, suppress the result
//   busy           : RUN or FIX in progress
//   res_vld        : result valid this cycle (FIX state, not flushed)
//   res_hi, res_lo : HI/LO result, meaningful only with res_vld
// Multiply: radix-2 shift-add on magnitudes, sign applied in FIX.
// Divide  : restoring on magnitudes, quotient/remainder signs applied in FIX.
module md_iter
  import alu_md_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             res_vld,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  localparam int AW = 2 * WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] x, input logic sgn);
    return (sgn && (x < 0)) ? -x : x;
  endfunction

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] x, input logic n);
    return n ? -x : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_if2(input logic [2*WIDTH-1:0] x, input logic n);
    return n ? -x : x;
  endfunction

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // Mul: {upper partial product, multiplier}. Div: {remainder, dividend/quotient}.
  logic [AW-1:0]      acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic               is_div_q, is_div_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dz_q, dz_d;

  logic               signed_op;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_diff;
  logic [AW-1:0]      div_sh;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod;

  // Operand latch
  assign signed_op = (op == MDOP_MULT) || (op == MDOP_DIV);
  assign a_mag     = mag(a, signed_op);
  assign b_mag     = mag(b, signed_op);

  // One iteration step
  assign mul_sum  = acc_q[AW-1:WIDTH] + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign div_sh   = {acc_q[AW-2:0], 1'b0};
  assign div_ge   = div_sh[AW-1:WIDTH] >= {1'b0, opnd_q};
  assign div_diff = div_sh[AW-1:WIDTH] - {1'b0, opnd_q};

  // Sign fixup
  assign prod = neg_if2(acc_q[2*WIDTH-1:0], neg_quo_q);
  assign busy = (state_q != MD_IDLE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    a_raw_d   = a_raw_q;
    is_div_d  = is_div_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    res_vld   = 1'b0;
    res_hi    = '0;
    res_lo    = '0;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          state_d   = MD_RUN;
          cnt_d     = '0;
          is_div_d  = (op == MDOP_DIV) || (op == MDOP_DIVU);
          acc_d     = {{(WIDTH + 1){1'b0}}, is_div_d ? a_mag : b_mag};
          opnd_d    = is_div_d ? b_mag : a_mag;
          a_raw_d   = a;
          neg_quo_d = signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_rem_d = signed_op && a[WIDTH-1];
          dz_d      = (b == '0);
        end
      end
      MD_RUN: begin
        if (is_div_q) begin
          acc_d = div_ge ? {div_diff, div_sh[WIDTH-1:1], 1'b1} : div_sh;
        end else begin
          acc_d = {1'b0, mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = MD_FIX;
        end
      end
      MD_FIX: begin
        state_d = MD_IDLE;
        res_vld = 1'b1;
        if (is_div_q) begin
          if (dz_q) begin
            res_hi = a_raw_q;
            res_lo = '1;
          end else begin
            res_hi = neg_if(acc_q[2*WIDTH-1:WIDTH], neg_rem_q);
            res_lo = neg_if(acc_q[WIDTH-1:0], neg_quo_q);
          end
        end else begin
          res_hi = prod[2*WIDTH-1:WIDTH];
          res_lo = prod[WIDTH-1:0];
        end
      end
      default: state_d = MD_IDLE;
    endcase
    if (flush) begin
      state_d = MD_IDLE;
      res_vld = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_q     <= acc_d;
    opnd_q    <= opnd_d;
    a_raw_q   <= a_raw_d;
    is_div_q  <= is_div_d;
    neg_quo_q <= neg_quo_d;
    neg_rem_q <= neg_rem_d;
    dz_q      <= dz_d;
  end

endmodule

// File: rtl/alu_md.sv
// alu_md: execute-stage arithmetic unit.
//   clk, rstn         : clock, asynchronous active-low reset
//   A, B, ALUOp       : operands and combinational opcode
//   C, Zero, Overflow : combinational result, A==B, signed overflow (ADD/SUB only)
//   md_op, md_start   : multiply/divide/HI-LO command and issue strobe
//   md_flush          : abort any in-flight mul/div
//   md_busy, md_done  : iterative op running / one-cycle result pulse
//   hi, lo            : HI/LO registers
module alu_md
  import alu_md_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       ALUOp,
  output logic [WIDTH-1:0] C,
  output logic             Zero,
  output logic             Overflow,
  input  logic [2:0]       md_op,
  input  logic             md_start,
  input  logic             md_flush,
  output logic             md_busy,
  output logic             md_done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [SHAMT_W-1:0]      sa;
  logic signed [WIDTH-1:0] a_s, b_s;
  logic [WIDTH-1:0]        sum, diff;

  // Shift amount sits in the instruction's shamt field position within B.
  assign sa   = B[6 +: SHAMT_W];
  assign a_s  = A;
  assign b_s  = B;
  assign sum  = A + B;
  assign diff = A - B;
  assign Zero = (A == B);

  always_comb begin
    C        = '0;
    Overflow = 1'b0;
    case (ALUOp)
      ALUOP_ADDU: C = sum;
      ALUOP_ADD: begin
        C        = sum;
        Overflow = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      ALUOP_SUBU: C = diff;
      ALUOP_SUB: begin
        C        = diff;
        Overflow = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      ALUOP_AND:  C = A & B;
      ALUOP_OR:   C = A | B;
      ALUOP_NOR:  C = ~(A | B);
      ALUOP_XOR:  C = A ^ B;
      ALUOP_SLT:  C = {{(WIDTH - 1){1'b0}}, (a_s < b_s)};
      ALUOP_SLTU: C = {{(WIDTH - 1){1'b0}}, (A < B)};
      ALUOP_SLL:  C = A << sa;
      ALUOP_SRL:  C = A >> sa;
      ALUOP_SRA:  C = a_s >>> sa;
      default:    C = '0;
    endcase
  end

  logic             accept, iter_start, res_vld;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;

  // Flush outranks a same-edge start; a start while busy is dropped.
  assign accept     = md_start && !md_busy && !md_flush;
  assign iter_start = accept && is_iter_op(md_op);

  md_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk     (clk),
    .rstn    (rstn),
    .start   (iter_start),
    .op      (md_op),
    .a       (A),
    .b       (B),
    .flush   (md_flush),
    .busy    (md_busy),
    .res_vld (res_vld),
    .res_hi  (res_hi),
    .res_lo  (res_lo)
  );

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = res_vld;
    if (res_vld) begin
      hi_d = res_hi;
      lo_d = res_lo;
    end
    if (accept && (md_op == MDOP_MTHI)) hi_d = A;
    if (accept && (md_op == MDOP_MTLO)) lo_d = A;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= done_d;
    end
  end

  assign hi      = hi_q;
  assign lo      = lo_q;
  assign md_done = done_q;

endmodule

// File: tb/tb_alu_md.sv
module tb_alu_md;
  import alu_md_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rstn;
  logic [W-1:0] A, B, C, hi, lo;
  logic [4:0]   ALUOp;
  logic         Zero, Overflow;
  logic [2:0]   md_op;
  logic         md_start, md_flush, md_busy, md_done;

  int n_cmp, n_bad;

  alu_md #(.WIDTH(W), .SHAMT_W(5)) dut (
    .clk(clk), .rstn(rstn), .A(A), .B(B), .ALUOp(ALUOp), .C(C), .Zero(Zero),
    .Overflow(Overflow), .md_op(md_op), .md_start(md_start), .md_flush(md_flush),
    .md_busy(md_busy), .md_done(md_done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        ov;
  } alu_vec_t;

  alu_vec_t vecs [13];

  logic [31:0] m_hi, m_lo, ec, eh, el, ra, rb;
  logic        eo, seen_done;
  logic [4:0]  rop;
  logic [2:0]  mop;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // Reference ALU computed with 64-bit signed arithmetic.
  function automatic void alu_ref(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] c, output logic ov);
    longint sa, sb, s;
    logic [4:0] sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = b[10:6];
    c  = 32'd0;
    ov = 1'b0;
    case (op)
      ALUOP_ADDU: c = a + b;
      ALUOP_ADD:  begin s = sa + sb; c = s[31:0]; ov = (s != longint'($signed(s[31:0]))); end
      ALUOP_SUBU: c = a - b;
      ALUOP_SUB:  begin s = sa - sb; c = s[31:0]; ov = (s != longint'($signed(s[31:0]))); end
      ALUOP_AND:  c = a & b;
      ALUOP_OR:   c = a | b;
      ALUOP_NOR:  c = ~(a | b);
      ALUOP_XOR:  c = a ^ b;
      ALUOP_SLT:  c = (sa < sb) ? 32'd1 : 32'd0;
      ALUOP_SLTU: c = (a < b) ? 32'd1 : 32'd0;
      ALUOP_SLL:  c = a << sh;
      ALUOP_SRL:  c = a >> sh;
      ALUOP_SRA:  begin s = sa >>> sh; c = s[31:0]; end
      default:    c = 32'd0;
    endcase
  endfunction

  // Reference mul/div using native 64-bit multiply, divide and remainder.
  function automatic void md_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] h, output logic [31:0] l);
    longint sa, sb;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    h = 32'd0;
    l = 32'd0;
    case (op)
      MDOP_MULT:  begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
      MDOP_MULTU: begin p = ua * ub; h = p[63:32]; l = p[31:0]; end
      MDOP_DIV, MDOP_DIVU: begin
        if (b == 32'd0) begin
          h = a;
          l = '1;
        end else if (op == MDOP_DIV) begin
          p = sa / sb; l = p[31:0];
          p = sa % sb; h = p[31:0];
        end else begin
          p = ua / ub; l = p[31:0];
          p = ua % ub; h = p[31:0];
        end
      end
      default: ;
    endcase
  endfunction

  // Called #1 after an edge; drives the command across the next edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    md_op = op; A = a; B = b; md_start = 1'b1;
    @(posedge clk); #1;
    md_start = 1'b0; md_op = MDOP_NONE;
    A = $urandom; B = $urandom;
    if (is_iter_op(op)) chk("busy after accept", 64'(md_busy), 64'd1);
  endtask

  task automatic wait_done(input string nm, input logic [31:0] xh, input logic [31:0] xl);
    int cyc;
    bit got;
    cyc = 0;
    got = 0;
    while (cyc < 40 && !got) begin
      @(posedge clk); #1;
      cyc++;
      if (md_done) got = 1;
    end
    chk({nm, " done latency"}, got ? 64'(cyc) : 64'd999, 64'd33);
    chk({nm, " busy in done"}, 64'(md_busy), 64'd0);
    chk({nm, " hi"}, 64'(hi), 64'(xh));
    chk({nm, " lo"}, 64'(lo), 64'(xl));
    m_hi = xh;
    m_lo = xl;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rstn = 1'b0; md_start = 1'b0; md_flush = 1'b0; md_op = MDOP_NONE;
    A = '0; B = '0; ALUOp = '0;

    vecs[0]  = '{ALUOP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1};
    vecs[1]  = '{ALUOP_ADDU, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0};
    vecs[2]  = '{ALUOP_SRA,  32'h80000000, 32'h00000100, 32'hF8000000, 1'b0};
    vecs[3]  = '{ALUOP_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1};
    vecs[4]  = '{ALUOP_SUBU, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0};
    vecs[5]  = '{ALUOP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0};
    vecs[6]  = '{ALUOP_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
    vecs[7]  = '{ALUOP_NOR,  32'h0F0F0000, 32'h00F0F000, 32'hF0000FFF, 1'b0};
    vecs[8]  = '{ALUOP_SLL,  32'h00000001, 32'h000007C0, 32'h80000000, 1'b0};
    vecs[9]  = '{ALUOP_SRL,  32'h80000000, 32'h000007C0, 32'h00000001, 1'b0};
    vecs[10] = '{5'd31,      32'h00000001, 32'h00000002, 32'h00000000, 1'b0};
    vecs[11] = '{ALUOP_AND,  32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 1'b0};
    vecs[12] = '{ALUOP_SUB,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    chk("reset busy", 64'(md_busy), 64'd0);
    chk("reset done", 64'(md_done), 64'd0);
    rstn = 1'b1;
    m_hi = 32'd0;
    m_lo = 32'd0;

    for (int i = 0; i < 13; i++) begin
      ALUOp = vecs[i].op; A = vecs[i].a; B = vecs[i].b;
      #1;
      chk("alu table C", 64'(C), 64'(vecs[i].c));
      chk("alu table ovf", 64'(Overflow), 64'(vecs[i].ov));
      chk("alu table zero", 64'(Zero), 64'(vecs[i].a == vecs[i].b));
    end

    for (int i = 0; i < 60; i++) begin
      rop = 5'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = (i % 8 == 0) ? ra : $urandom;
      ALUOp = rop; A = ra; B = rb;
      #1;
      alu_ref(rop, ra, rb, ec, eo);
      chk("alu rand C", 64'(C), 64'(ec));
      chk("alu rand ovf", 64'(Overflow), 64'(eo));
      chk("alu rand zero", 64'(Zero), 64'(ra == rb));
    end

    @(posedge clk); #1;
    issue(MDOP_MULT, 32'hFFFFFFFF, 32'd2);
    wait_done("MULT -1*2", 32'hFFFFFFFF, 32'hFFFFFFFE);
    issue(MDOP_MULTU, 32'hFFFFFFFF, 32'd2);
    wait_done("MULTU", 32'h00000001, 32'hFFFFFFFE);
    issue(MDOP_DIV, 32'hFFFFFFF9, 32'd2);
    wait_done("DIV -7/2", 32'hFFFFFFFF, 32'hFFFFFFFD);
    issue(MDOP_DIVU, 32'd7, 32'd0);
    wait_done("DIVU /0", 32'd7, 32'hFFFFFFFF);
    issue(MDOP_DIV, 32'hFFFFFFFB, 32'd0);
    wait_done("DIV -5/0", 32'hFFFFFFFB, 32'hFFFFFFFF);
    issue(MDOP_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done("DIV MIN/-1", 32'h00000000, 32'h80000000);

    for (int i = 0; i < 12; i++) begin
      mop = 3'(1 + $urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = -32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      md_ref(mop, ra, rb, eh, el);
      issue(mop, ra, rb);
      wait_done("md rand", eh, el);
    end

    // Flush mid-MULT; a stray start while busy must be dropped.
    issue(MDOP_MULT, 32'h00001234, 32'h00005678);
    seen_done = 1'b0;
    for (int c = 1; c < 10; c++) begin
      if (c == 5) begin
        md_op = MDOP_MTHI; A = 32'hDEADBEEF; md_start = 1'b1;
      end
      @(posedge clk); #1;
      md_start = 1'b0; md_op = MDOP_NONE;
      if (md_done) seen_done = 1'b1;
    end
    chk("busy before flush", 64'(md_busy), 64'd1);
    md_flush = 1'b1;
    @(posedge clk); #1;
    md_flush = 1'b0;
    chk("busy after flush", 64'(md_busy), 64'd0);
    repeat (40) begin
      @(posedge clk); #1;
      if (md_done) seen_done = 1'b1;
    end
    chk("flush no done", 64'(seen_done), 64'd0);
    chk("flush hi kept", 64'(hi), 64'(m_hi));
    chk("flush lo kept", 64'(lo), 64'(m_lo));

    issue(MDOP_MTLO, 32'h00001234, 32'd0);
    chk("MTLO lo", 64'(lo), 64'h1234);
    chk("MTLO no done", 64'(md_done), 64'd0);
    chk("MTLO no busy", 64'(md_busy), 64'd0);
    m_lo = 32'h00001234;

    issue(MDOP_MULT, 32'd3, 32'd5);
    wait_done("MULT 3*5", 32'd0, 32'd15);
    issue(MDOP_MTHI, 32'h0000CAFE, 32'd0);
    chk("MTHI in done cycle", 64'(hi), 64'hCAFE);
    chk("MTHI lo kept", 64'(lo), 64'd15);
    issue(MDOP_MULT, 32'h00000010, 32'hFFFFFFFD);
    wait_done("MULT 16*-3", 32'hFFFFFFFF, 32'hFFFFFFD0);
    issue(MDOP_MULTU, 32'h00010000, 32'h00010000);
    wait_done("MULTU b2b", 32'h00000001, 32'h00000000);

    // Asynchronous reset in the middle of a divide.
    issue(MDOP_DIV, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("rst mid hi", 64'(hi), 64'd0);
    chk("rst mid lo", 64'(lo), 64'd0);
    chk("rst mid busy", 64'(md_busy), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post rst busy", 64'(md_busy), 64'd0);
    chk("post rst done", 64'(md_done), 64'd0);
    issue(MDOP_DIV, 32'd100, 32'hFFFFFFF9);
    wait_done("DIV after rst", 32'd2, 32'hFFFFFFF2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
